ddr_capture_sched: RTL and testbench
====================================

DDR_CAPTURE_SCHED -- requirements
Module: ddr_capture_sched

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, number of buffered pair words; SHALL be a power of two, minimum 2.
REQ-002 Parameter CNT_W, default 8, width of the pair-count request.
REQ-003 Port clk  in  1  sole clock; posedge and negedge both used.
REQ-004 Port rst  in  1  reset, synchronous, active-high.
REQ-005 Port data  in  8  sampled bus.
REQ-006 Port start  in  1  one-cycle request to begin a capture burst.
REQ-007 Port count  in  CNT_W  number of pair words to capture, latched on accepted start.
REQ-008 Port out_data  out  16 (17 with parity)  FIFO head word {neg_sample, pos_sample}.
REQ-009 Port out_valid  out  1  FIFO non-empty.
REQ-010 Port out_ready  in  1  consumer accept; pop when out_valid && out_ready at posedge.
REQ-011 Port busy  out  1  high in CAPTURE and DRAIN.
REQ-012 Port done  out  1  one-cycle pulse at burst completion.
REQ-013 Port overflow  out  1  sticky; set when a pair word is dropped.

Function
REQ-014 neg_sample register SHALL load data on every negedge clk, or 8'hFF when rst is high at that negedge.
REQ-015 FSM states SHALL be IDLE, CAPTURE, DRAIN, DONE; all transitions at posedge.
REQ-016 IDLE: start && count!=0 -> CAPTURE, remaining<=count; start && count==0 -> DONE; otherwise stay.
REQ-017 start SHALL be ignored outside IDLE.
REQ-018 CAPTURE: each posedge pushes {neg_sample, data} and decrements remaining; after the push with remaining==1 -> DRAIN.
REQ-019 First push SHALL occur on the posedge after the one that accepted start; exactly count pushes attempted.
REQ-020 Push while FIFO full and no simultaneous pop: word dropped, overflow<=1, remaining still decrements.
REQ-021 Push and pop in the same cycle while full: both occur, no overflow.
REQ-022 out_data/out_valid SHALL present the FIFO head combinationally from storage (first-word fall-through); the word is visible one posedge after its push.
REQ-023 DRAIN: stay until FIFO empty, then -> DONE; DONE -> IDLE after one cycle with done=1.
REQ-024 overflow SHALL clear only on reset or on the next accepted start.
REQ-025 FIFO pointers SHALL wrap modulo FIFO_DEPTH; occupancy tracked with one extra bit.

Reset
REQ-026 rst at posedge: state IDLE, FIFO empty, remaining 0, out_valid 0, busy 0, done 0, overflow 0; out_data value is don't-care while out_valid is 0.
REQ-027 rst mid-burst SHALL abort immediately; buffered words are discarded and no done pulse is issued.

Configuration
REQ-028 Macro DDR_SCHED_PARITY_EN defined: out_data widens to 17 bits with bit 16 = even parity (XOR) of bits 15:0, computed at push. Undefined: 16 bits, no parity logic.

Structure
REQ-029 Package ddr_sched_pkg SHALL hold the state enum typedef, the pair-word width constant and the parity width constant.
REQ-030 The FIFO SHALL be a sub-module ddr_sched_fifo, parameterised by depth and width, exposing full/empty.

Verification
REQ-031 Reset: rst=1 for 2 cycles -> busy=0, out_valid=0, overflow=0, done=0; neg_sample=8'hFF.
REQ-032 count=3, data=8'hA0 at negedges and 8'h0A at posedges, out_ready=1 -> three words 16'hA00A; done pulses once; busy drops with done.
REQ-033 count=6, out_ready=0 -> first 4 words stored, 2 dropped, overflow=1; after out_ready=1, 4 words drain, then done.
REQ-034 count=0 -> done pulses the cycle after start, no push, busy stays 0.
REQ-035 rst asserted after 2 of 5 pushes -> out_valid=0 next cycle, state IDLE, no done pulse.
REQ-036 With DDR_SCHED_PARITY_EN: word 16'h0103 -> bit16=1; 16'h0303 -> bit16=0.

Source files
------------

// File: rtl/ddr_sched_pkg.sv
// Shared types and widths for the DDR capture scheduler.
// The optional parity bit is enabled by defining DDR_SCHED_PARITY_EN.
package ddr_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_DRAIN   = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam int PAIR_W = 16;
`ifdef DDR_SCHED_PARITY_EN
  localparam int PAR_W  = 1;
`else
  localparam int PAR_W  = 0;
`endif
  localparam int OUT_W  = PAIR_W + PAR_W;

endpackage

// File: rtl/ddr_sched_fifo.sv
// First-word fall-through FIFO for captured pair words.
// Storage is read combinationally at the read pointer; pointers carry one wrap bit.
module ddr_sched_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A push into a full FIFO still lands when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/ddr_capture_sched.sv
// Captures data on both clock edges as {neg, pos} pair words for a counted burst.
// Define DDR_SCHED_PARITY_EN to append an even-parity bit (bit 16) to each word.
module ddr_capture_sched
  import ddr_sched_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       data,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done,
  output logic             overflow
);

  state_t             state, nstate;
  logic [CNT_W-1:0]   remaining;
  logic [7:0]         neg_sample;
  logic [PAIR_W-1:0]  pair;
  logic [OUT_W-1:0]   wdata;
  logic               push, accept, full, empty, drop;

  // Falling-edge half of the pair; reset value marks "no sample yet".
  always_ff @(negedge clk) begin
    if (rst) neg_sample <= 8'hFF;
    else     neg_sample <= data;
  end

  assign pair = {neg_sample, data};
`ifdef DDR_SCHED_PARITY_EN
  assign wdata = {^pair, pair};
`else
  assign wdata = pair;
`endif

  ddr_sched_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(OUT_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (out_ready),
    .wdata (wdata),
    .rdata (out_data),
    .full  (full),
    .empty (empty)
  );

  assign out_valid = !empty;
  assign accept    = (state == S_IDLE) && start;
  // full implies non-empty, so out_ready alone decides whether the head leaves.
  assign drop      = push && full && !out_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      S_IDLE:    if (start) nstate = (count != '0) ? S_CAPTURE : S_DONE;
      S_CAPTURE: if (remaining == CNT_W'(1)) nstate = S_DRAIN;
      S_DRAIN:   if (empty) nstate = S_DONE;
      S_DONE:    nstate = S_IDLE;
      default:   nstate = S_IDLE;
    endcase
  end

  always_comb begin
    push = (state == S_CAPTURE);
    busy = (state == S_CAPTURE) || (state == S_DRAIN);
    done = (state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      remaining <= '0;
      overflow  <= 1'b0;
    end else begin
      if (accept) begin
        remaining <= count;
        overflow  <= 1'b0;
      end else if (push) begin
        remaining <= remaining - 1'b1;
      end
      if (drop) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ddr_capture_sched.sv
// Scoreboard bench for ddr_capture_sched: a queue-level model predicts words,
// drops and overflow; a negedge monitor compares every handshaked word.
module tb_ddr_capture_sched;
  import ddr_sched_pkg::*;

  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [7:0]       data = 8'h00;
  logic             start = 1'b0;
  logic [7:0]       count = 8'h00;
  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic             busy, done, overflow;

  ddr_capture_sched #(.FIFO_DEPTH(DEPTH), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .data      (data),
    .start     (start),
    .count     (count),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  // Reference model: expected word stream, occupancy, pending captures, drops.
  logic [OUT_W-1:0] exp_q[$];
  int m_occ = 0;
  int m_cap = 0;
  int m_drops = 0;

  function automatic logic [OUT_W-1:0] ref_word(input logic [7:0] n, input logic [7:0] p);
    logic [15:0] w;
    w = {n, p};
`ifdef DDR_SCHED_PARITY_EN
    return {^w, w};
`else
    return w;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Monitor: consumes one expected word per handshake, counts done pulses.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt++;
      chk("busy_at_done", 32'(busy), 32'd0);
    end
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got %0h expected none", out_data);
      end else begin
        chk("word", 32'(out_data), 32'(exp_q.pop_front()));
      end
    end
  end

  // One clock: inputs set after posedge (neg half) and after negedge (pos half);
  // the model then advances for the posedge that will sample them.
  task automatic cyc(input logic r, input logic st, input logic [7:0] cnt,
                     input logic rdy, input logic [7:0] dn, input logic [7:0] dp);
    logic pop;
    @(posedge clk); #1;
    rst = r; start = st; count = cnt; out_ready = rdy; data = dn;
    @(negedge clk); #1;
    data = dp;
    chk("out_valid", 32'(out_valid), 32'(m_occ > 0));
    chk("overflow", 32'(overflow), 32'(m_drops > 0));
    if (r) begin
      exp_q.delete();
      m_occ = 0; m_cap = 0; m_drops = 0;
    end else begin
      pop = rdy && (m_occ > 0);
      if (m_cap > 0) begin
        if (m_occ < DEPTH || pop) begin
          exp_q.push_back(ref_word(dn, dp));
          m_occ++;
        end else begin
          m_drops++;
        end
        m_cap--;
      end
      if (pop) m_occ--;
      if (st) begin
        m_cap = int'(cnt);
        m_drops = 0;
      end
    end
  endtask

  // rmode 0: ready held high, 1: random ready, 2: ready low for 10 cycles then high.
  task automatic finish_burst(input int rmode, input logic rnd, input logic [7:0] dn, input logic [7:0] dp);
    int d0;
    logic rdy;
    d0 = done_cnt;
    for (int i = 0; i < 300; i++) begin
      if (done_cnt != d0) break;
      case (rmode)
        0:       rdy = 1'b1;
        1:       rdy = 1'($urandom);
        default: rdy = (i >= 10);
      endcase
      if (rnd) cyc(1'b0, 1'b0, 8'd0, rdy, 8'($urandom), 8'($urandom));
      else     cyc(1'b0, 1'b0, 8'd0, rdy, dn, dp);
    end
    chk("done_pulses", 32'(done_cnt - d0), 32'd1);
    chk("drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int d0;
    logic [7:0] c;

    // Reset held two cycles.
    cyc(1'b1, 1'b0, 8'd0, 1'b0, 8'h00, 8'h00);
    cyc(1'b1, 1'b0, 8'd0, 1'b0, 8'h00, 8'h00);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_neg_sample", 32'(dut.neg_sample), 32'hFF);

    // count=3 with A0 on falling edges and 0A on rising edges.
    cyc(1'b0, 1'b1, 8'd3, 1'b1, 8'hA0, 8'h0A);
    finish_burst(0, 1'b0, 8'hA0, 8'h0A);
    chk("busy_after_done", 32'(busy), 32'd0);

    // count=6 with consumer stalled: 4 stored, 2 dropped.
    cyc(1'b0, 1'b1, 8'd6, 1'b0, 8'($urandom), 8'($urandom));
    finish_burst(2, 1'b1, 8'h00, 8'h00);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    chk("ovf_drops", 32'(m_drops), 32'd2);

    // count=0: done the cycle after start, no push; overflow cleared by the start.
    cyc(1'b0, 1'b1, 8'd0, 1'b1, 8'h11, 8'h22);
    cyc(1'b0, 1'b0, 8'd0, 1'b1, 8'h11, 8'h22);
    chk("zero_done", 32'(done), 32'd1);
    chk("zero_busy", 32'(busy), 32'd0);
    cyc(1'b0, 1'b0, 8'd0, 1'b1, 8'h11, 8'h22);
    chk("zero_done_clear", 32'(done), 32'd0);
    chk("zero_busy2", 32'(busy), 32'd0);

    // Reset after 2 of 5 pushes: abort, no done.
    d0 = done_cnt;
    cyc(1'b0, 1'b1, 8'd5, 1'b0, 8'h31, 8'h32);
    cyc(1'b0, 1'b0, 8'd0, 1'b0, 8'h41, 8'h42);
    cyc(1'b0, 1'b0, 8'd0, 1'b0, 8'h51, 8'h52);
    cyc(1'b1, 1'b0, 8'd0, 1'b0, 8'h61, 8'h62);
    chk("abort_valid_pre", 32'(out_valid), 32'd1);
    chk("abort_neg_sample", 32'(dut.neg_sample), 32'hFF);
    cyc(1'b0, 1'b0, 8'd0, 1'b1, 8'h71, 8'h72);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_state", 32'(dut.state), 32'(S_IDLE));
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 8'd0, 1'b1, 8'h00, 8'h00);
    chk("abort_no_done", 32'(done_cnt - d0), 32'd0);

    // Parity pattern words 0103 and 0303.
    cyc(1'b0, 1'b1, 8'd2, 1'b1, 8'h01, 8'h03);
    cyc(1'b0, 1'b0, 8'd0, 1'b1, 8'h01, 8'h03);
    cyc(1'b0, 1'b0, 8'd0, 1'b1, 8'h03, 8'h03);
    finish_burst(0, 1'b0, 8'h00, 8'h00);

    // Randomised bursts.
    for (int b = 0; b < 10; b++) begin
      c = 8'($urandom_range(1, 10));
      cyc(1'b0, 1'b1, c, 1'($urandom), 8'($urandom), 8'($urandom));
      finish_burst(1, 1'b1, 8'h00, 8'h00);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
